// File: rtl/regfile_write_arbiter.sv
// Two-port write arbiter for the register file write port.
// Port 0 is core writeback, port 1 is the debug/test loader. Port 1 can
// hold the port for a locked burst. After MAX_LOCK cycles in the lock, a
// waiting port-0 request preempts that burst.
// Optional build macro: RFARB_STATS_EN adds saturating grant and
// preemption counters as extra outputs.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              lock_active
`ifdef RFARB_STATS_EN
  ,
  output logic [15:0]       grant0_cnt,
  output logic [15:0]       grant1_cnt,
  output logic [15:0]       preempt_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {ST_RR = 1'b0, ST_LOCK1 = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               rf_we_q;
  logic [ADDR_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0]  rf_wdata_q;
  logic               preempt;
  logic               xfer0;
  logic               xfer1;
  logic               cnt_at_max;

  assign cnt_at_max = (lock_cnt_q == CNT_W'(MAX_LOCK));
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  // Grant decision: pure function of state, last grant, lock count and valids.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    preempt    = 1'b0;
    case (state_q)
      ST_RR: begin
        if (req0_valid && req1_valid) begin
          // Tie goes to the port opposite the last one served.
          if (last_grant_q) req0_ready = 1'b1;
          else              req1_ready = 1'b1;
        end else if (req0_valid) begin
          req0_ready = 1'b1;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
        end
      end
      ST_LOCK1: begin
        if (cnt_at_max && req0_valid) begin
          req0_ready = 1'b1;
          preempt    = 1'b1;
        end else begin
          req1_ready = req1_valid;
        end
      end
      default: ;
    endcase
  end

  // Next-state: lock entry/exit, lock age counter, round-robin pointer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    if (xfer0) last_grant_d = 1'b0;
    if (xfer1) last_grant_d = 1'b1;
    case (state_q)
      ST_RR: begin
        if (xfer1 && req1_lock) begin
          state_d    = ST_LOCK1;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ST_LOCK1: begin
        // The lock ages every cycle, idle or not, and saturates.
        lock_cnt_d = cnt_at_max ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
        if (preempt) begin
          state_d      = ST_RR;
          lock_cnt_d   = '0;
          last_grant_d = 1'b0;
        end else if (xfer1 && !req1_lock) begin
          state_d      = ST_RR;
          lock_cnt_d   = '0;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RR;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Registered write port. Writes to x0 update address/data but do not enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (xfer0) begin
        rf_we_q    <= (req0_addr != '0);
        rf_waddr_q <= req0_addr;
        rf_wdata_q <= req0_data;
      end else if (xfer1) begin
        rf_we_q    <= (req1_addr != '0);
        rf_waddr_q <= req1_addr;
        rf_wdata_q <= req1_data;
      end
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign lock_active = (state_q == ST_LOCK1);

`ifdef RFARB_STATS_EN
  logic [15:0] grant0_cnt_q, grant1_cnt_q, preempt_cnt_q;

  // Saturating event counters for transfers and preemptions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt_q  <= '0;
      grant1_cnt_q  <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (xfer0 && grant0_cnt_q != 16'hFFFF)    grant0_cnt_q  <= grant0_cnt_q + 16'd1;
      if (xfer1 && grant1_cnt_q != 16'hFFFF)    grant1_cnt_q  <= grant1_cnt_q + 16'd1;
      if (preempt && preempt_cnt_q != 16'hFFFF) preempt_cnt_q <= preempt_cnt_q + 16'd1;
    end
  end

  assign grant0_cnt  = grant0_cnt_q;
  assign grant1_cnt  = grant1_cnt_q;
  assign preempt_cnt = preempt_cnt_q;
`endif

endmodule
